// File: rtl/mux_scan_sequencer.sv
// Purpose : sweeps the select lines of a 4:1 mux, waits SETTLE_CYCLES+1 cycles per
//           channel and snapshots the four mux outputs into one 4-bit word.
// Latency : start edge to valid = 4*(SETTLE_CYCLES+1) cycles; channel k captured at
//           edge (k+1)*(SETTLE_CYCLES+1).
// Backpressure: result/valid hold indefinitely in HOLD until ready; start together
//           with ready in HOLD begins the next scan on the same edge.
//
// Ports:
//   clk       in   rising-edge system clock
//   reset_n   in   asynchronous active-low reset
//   start     in   begin a scan (honoured in IDLE, or in HOLD together with ready)
//   abort     in   synchronous cancel, overrides every other input
//   mux_out   in   mux out pin
//   address0  out  mux select LSB (registered)
//   address1  out  mux select MSB (registered)
//   result    out  captured word, result[i] sampled with select == i
//   valid     out  result holds a complete, unconsumed scan
//   ready     in   downstream accepts result
//   busy      out  scan in progress (SETTLE or SAMPLE)

module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic       address0,
    output logic       address1,
    output logic [3:0] result,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Counter counts down to zero, so SETTLE lasts SETTLE_CYCLES cycles and the
    // following SAMPLE cycle brings the address hold time to SETTLE_CYCLES+1.
    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_idx;
    logic [7:0]  r_cnt;
    logic [3:0]  r_shadow;
    logic [3:0]  r_result;
    logic [1:0]  r_address;
    logic        r_valid;
    logic        r_busy;

    logic [1:0]  w_idx_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [3:0]  w_shadow_nxt;
    logic [3:0]  w_result_nxt;
    logic [1:0]  w_address_nxt;
    logic        w_valid_nxt;
    logic        w_busy_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort overrides every transition
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
                ST_HOLD: begin
                    if (ready) begin
                        // Accept edge doubles as edge 0 of a back-to-back scan.
                        w_state_nxt = start ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. Outputs are registered from these so
    // no input reaches an output port without passing through a flop.
    // ------------------------------------------------------------------
    always_comb begin
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_result_nxt = r_result;

        if (abort) begin
            // Partial samples are discarded; the last completed result survives.
            w_idx_nxt    = 2'd0;
            w_cnt_nxt    = 8'd0;
            w_shadow_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_idx_nxt = 2'd0;
                        w_cnt_nxt = CNT_RELOAD;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != 8'd0) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    w_shadow_nxt[r_idx] = mux_out;
                    if (r_idx == 2'd3) begin
                        // Final channel goes straight into result alongside the
                        // three earlier shadow bits.
                        w_result_nxt = {mux_out, r_shadow[2:0]};
                        w_idx_nxt    = 2'd0;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                        w_cnt_nxt = CNT_RELOAD;
                    end
                end
                ST_HOLD: begin
                    if (ready && start) begin
                        w_idx_nxt = 2'd0;
                        w_cnt_nxt = CNT_RELOAD;
                    end
                end
                default: begin
                    w_idx_nxt = 2'd0;
                    w_cnt_nxt = 8'd0;
                end
            endcase
        end

        w_busy_nxt    = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
        w_valid_nxt   = (w_state_nxt == ST_HOLD);
        // Select lines follow the channel being settled; parked at 00 otherwise.
        w_address_nxt = w_busy_nxt ? w_idx_nxt : 2'd0;
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= 2'd0;
            r_cnt     <= 8'd0;
            r_shadow  <= 4'd0;
            r_result  <= 4'd0;
            r_address <= 2'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shadow  <= w_shadow_nxt;
            r_result  <= w_result_nxt;
            r_address <= w_address_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign address0 = r_address[0];
    assign address1 = r_address[1];
    assign result   = r_result;
    assign valid    = r_valid;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Purpose : directed + randomized bench for mux_scan_sequencer with a behavioural
//           4:1 mux and a timing-formula reference model.
// Latency : instance 0 uses SETTLE_CYCLES=4, instance 1 uses SETTLE_CYCLES=1.
// Backpressure: ready is driven per step; HOLD stalls are exercised explicitly.

module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start;
    logic       ready;
    logic       abort;
    logic       sel;
    logic [3:0] in_vec [2];

    int n_assert = 0;
    int n_fail   = 0;

    // Instance 0: default settle time
    logic       start_0, ready_0, abort_0, mux_out_0;
    logic       a0_0, a1_0, vld_0, busy_0;
    logic [3:0] res_0;
    // Instance 1: SETTLE_CYCLES = 1
    logic       start_1, ready_1, abort_1, mux_out_1;
    logic       a0_1, a1_1, vld_1, busy_1;
    logic [3:0] res_1;

    assign start_0 = (sel == 1'b0) ? start : 1'b0;
    assign ready_0 = (sel == 1'b0) ? ready : 1'b0;
    assign abort_0 = (sel == 1'b0) ? abort : 1'b0;
    assign start_1 = (sel == 1'b1) ? start : 1'b0;
    assign ready_1 = (sel == 1'b1) ? ready : 1'b0;
    assign abort_1 = (sel == 1'b1) ? abort : 1'b0;

    // Behavioural 4:1 multiplexers
    assign mux_out_0 = in_vec[0][{a1_0, a0_0}];
    assign mux_out_1 = in_vec[1][{a1_1, a0_1}];

    mux_scan_sequencer #(.SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start_0), .abort(abort_0),
        .mux_out(mux_out_0), .address0(a0_0), .address1(a1_0),
        .result(res_0), .valid(vld_0), .ready(ready_0), .busy(busy_0)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_1), .abort(abort_1),
        .mux_out(mux_out_1), .address0(a0_1), .address1(a1_1),
        .result(res_1), .valid(vld_1), .ready(ready_1), .busy(busy_1)
    );

    function automatic logic [1:0] addr_of(input logic d);
        return d ? {a1_1, a0_1} : {a1_0, a0_0};
    endfunction
    function automatic logic [3:0] res_of(input logic d);
        return d ? res_1 : res_0;
    endfunction
    function automatic logic vld_of(input logic d);
        return d ? vld_1 : vld_0;
    endfunction
    function automatic logic busy_of(input logic d);
        return d ? busy_1 : busy_0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input logic d);
        check("rst_addr",   32'(addr_of(d)), 32'd0);
        check("rst_result", 32'(res_of(d)),  32'd0);
        check("rst_valid",  32'(vld_of(d)),  32'd0);
        check("rst_busy",   32'(busy_of(d)), 32'd0);
    endtask

    // Runs one scan on the selected instance. Reference model: the select must
    // equal e/(s+1) after edge e, and channel k is whatever in[k] holds at edge
    // (k+1)(s+1). With rnd set, inputs, start and ready are scrambled every
    // cycle to show they are sampled only at the capture edges / ignored.
    task automatic do_scan(input int s, input bit rnd, input bit accept, output logic [3:0] expv);
        int t;
        int k;
        t    = 4 * (s + 1);
        expv = 4'd0;
        start = 1'b1;
        ready = accept;
        tick();
        start = 1'b0;
        ready = 1'b0;
        for (int e = 0; e < t; e++) begin
            check("scan_addr",  32'(addr_of(sel)), 32'(e / (s + 1)));
            check("scan_busy",  32'(busy_of(sel)), 32'd1);
            check("scan_valid", 32'(vld_of(sel)),  32'd0);
            if (rnd) begin
                in_vec[sel] = 4'($urandom);
                start       = 1'($urandom);
                ready       = 1'($urandom);
            end
            if (((e + 1) % (s + 1)) == 0) begin
                k = (e + 1) / (s + 1) - 1;
                expv[k] = in_vec[sel][k];
            end
            tick();
        end
        start = 1'b0;
        ready = 1'b0;
        check("done_valid",  32'(vld_of(sel)),  32'd1);
        check("done_busy",   32'(busy_of(sel)), 32'd0);
        check("done_addr",   32'(addr_of(sel)), 32'd0);
        check("done_result", 32'(res_of(sel)),  32'(expv));
    endtask

    initial begin
        logic [3:0] ev;
        logic [3:0] prior;
        bit         acc;

        reset_n   = 1'b1;
        start     = 1'b0;
        ready     = 1'b0;
        abort     = 1'b0;
        sel       = 1'b0;
        in_vec[0] = 4'd0;
        in_vec[1] = 4'd0;
        #1 reset_n = 1'b0;
        #2;
        check_zero(1'b0);
        check_zero(1'b1);
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
        check_zero(1'b0);

        // Basic scan, in0..in3 = 1,0,1,1
        sel       = 1'b0;
        in_vec[0] = 4'b1101;
        do_scan(4, 1'b0, 1'b0, ev);
        check("tp1_result", 32'(res_0), 32'b1101);

        // Minimum settle time, in0..in3 = 0,1,1,0
        sel       = 1'b1;
        in_vec[1] = 4'b0110;
        do_scan(1, 1'b0, 1'b0, ev);
        check("tp2_result", 32'(res_1), 32'b0110);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("tp2_accept_valid", 32'(vld_1), 32'd0);
        tick();
        check("tp2_idle_busy", 32'(busy_1), 32'd0);

        // Backpressure: instance 0 still holds 1101
        sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_vec[0] = 4'($urandom);
            start     = 1'(i % 2);
            tick();
            check("hold_result", 32'(res_0),  32'b1101);
            check("hold_valid",  32'(vld_0),  32'd1);
            check("hold_busy",   32'(busy_0), 32'd0);
        end
        start = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("accept_valid", 32'(vld_0),  32'd0);
        check("accept_busy",  32'(busy_0), 32'd0);
        tick();
        check("idle_valid", 32'(vld_0),  32'd0);
        check("idle_busy",  32'(busy_0), 32'd0);

        // Randomized scan, then a back-to-back scan with in0..in3 = 0,0,0,1
        in_vec[0] = 4'($urandom);
        do_scan(4, 1'b1, 1'b0, ev);
        in_vec[0] = 4'b1000;
        do_scan(4, 1'b0, 1'b1, ev);
        check("b2b_result", 32'(res_0), 32'b1000);

        // Random mix of back-to-back and accept-then-start scans
        for (int i = 0; i < 6; i++) begin
            acc = 1'($urandom_range(0, 1));
            if (!acc) begin
                ready = 1'b1;
                tick();
                ready = 1'b0;
                check("rnd_accept_valid", 32'(vld_0), 32'd0);
            end
            in_vec[0] = 4'($urandom);
            do_scan(4, 1'b1, acc, ev);
        end

        // Abort in HOLD clears valid and keeps result
        prior = res_0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_hold_valid",  32'(vld_0), 32'd0);
        check("abort_hold_result", 32'(res_0), 32'(prior));
        // Abort together with start in IDLE: no scan
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", 32'(busy_0), 32'd0);
        // Abort at edge 12 of a scan
        in_vec[0] = ~prior;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",   32'(busy_0),     32'd0);
        check("abort_addr",   32'(addr_of(0)), 32'd0);
        check("abort_valid",  32'(vld_0),      32'd0);
        check("abort_result", 32'(res_0),      32'(prior));
        for (int i = 0; i < 25; i++) begin
            tick();
            check("post_abort_valid", 32'(vld_0), 32'd0);
        end
        in_vec[0] = 4'($urandom);
        do_scan(4, 1'b0, 1'b0, ev);

        // Asynchronous reset mid-SETTLE of channel 2
        ready = 1'b1;
        tick();
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("pre_reset_addr", 32'(addr_of(0)), 32'd2);
        check("pre_reset_busy", 32'(busy_0),     32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_zero(1'b0);
        check_zero(1'b1);
        tick();
        #2 reset_n = 1'b1;
        tick();
        check_zero(1'b0);
        in_vec[0] = 4'($urandom);
        do_scan(4, 1'b1, 1'b0, ev);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Clocked sequencer that sweeps the select lines of the team's 4:1 multiplexer through all four addresses, waits a programmable number of cycles for the gate-level mux output to settle, and samples the result into a 4-bit word. It drives `address0`/`address1` into the mux and consumes the mux `out` pin. It then presents the captured word downstream with a valid/ready handshake. It turns the combinational mux with its gate delays into a deterministic, cycle-accurate parallel snapshot.

## Interface
- `SETTLE_CYCLES`, default 4: wait cycles after each address change before sampling; legal range 1..255 (8-bit counter).
- `clk`  in  1  system clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a scan; sampled only in IDLE, or in HOLD together with `ready`.
- `abort`  in  1  synchronous cancel; priority over all other inputs except reset.
- `mux_out`  in  1  mux `out` pin.
- `address0`  out  1  mux select LSB, registered.
- `address1`  out  1  mux select MSB, registered.
- `result`  out  4  captured word; `result[i]` is the sample taken with `{address1,address0}==i`.
- `valid`  out  1  `result` holds a complete, unconsumed scan.
- `ready`  in  1  downstream accepts `result`.
- `busy`  out  1  scan in progress, in SETTLE or SAMPLE.

## Operation
- States:
  - IDLE, SETTLE, SAMPLE and HOLD, plus a 2-bit channel index `idx` and an 8-bit settle counter `cnt`.
  - Partial samples go to an internal 4-bit shadow register. `result` updates only on the final capture.
- IDLE:
  - Address is 00, `busy`=0, `valid`=0.
  - `start`=1 at an edge: go to SETTLE with `idx`=0 and `cnt`=SETTLE_CYCLES-1.
- SETTLE:
  - `cnt`≠0: decrement `cnt`.
  - `cnt`==0: go to SAMPLE.
  - Address holds `idx` throughout.
- SAMPLE, one cycle. At the exit edge, write `shadow[idx]`←`mux_out`, then:
  - `idx`<3: `idx`++, address←`idx`+1, reload `cnt`, go to SETTLE.
  - `idx`==3: `result`←{`mux_out`, `shadow[2:0]`}, `valid`←1, address←00, go to HOLD.
- HOLD:
  - `valid`=1 and `result` is stable.
  - `ready`=1 at an edge: `valid`←0. If `start`=1 at the same edge, go to SETTLE with `idx`=0 (back-to-back scan); otherwise go to IDLE.
  - `ready`=0: hold indefinitely.
- `start` is ignored in SETTLE and SAMPLE.
- `abort`=1 at an edge in any state:
  - Go to IDLE; address←00, `valid`←0.
  - Discard the shadow register; `result` keeps its last value.
  - `abort` and `start` together: `abort` wins, so no scan starts.
- Reset (`reset_n`=0), asynchronous and immediate, in any state including mid-scan:
  - Go to IDLE with `idx`=0 and `cnt`=0.
  - Address 00, `result`=0000, `valid`=0, `busy`=0, shadow=0000.

## Timing
- Reset values: `address0`=0, `address1`=0, `result`=0, `valid`=0, `busy`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- With `start` seen at edge 0:
  - Channel k is captured at edge 5(k+1) for SETTLE_CYCLES=4; in general at edge (k+1)(SETTLE_CYCLES+1).
  - `valid` rises after edge 4(SETTLE_CYCLES+1), which is 20 at the default.
- Before each capture, the address is stable for SETTLE_CYCLES+1 full cycles.
- `busy` is 1 from edge 0 through the final capture edge.
- Back-to-back throughput: one scan per 4(SETTLE_CYCLES+1) cycles. The accept edge in HOLD equals edge 0 of the next scan.
- Handshake:
  - The transfer occurs at the edge where `valid`&`ready`.
  - `result` must not change while `valid`=1 and `ready`=0.

## Test plan
- Reset, then mux inputs in0..in3=1,0,1,1 and `start` pulsed one cycle → `valid`=1 after edge 20, `result`=4'b1101, address back to 00, `busy`=0.
- SETTLE_CYCLES=1 with in0..in3=0,1,1,0 → `valid` after edge 8, `result`=4'b0110. Checks that address changes at edges 2, 4 and 6.
- Hold `ready`=0 for 10 cycles in HOLD while toggling mux inputs and pulsing `start` → `result` and `valid` unchanged, no new scan. Then `ready`=1 → `valid` falls next edge, state IDLE.
- `ready`=1 and `start`=1 at the same HOLD edge, in0..in3 changed to 0,0,0,1 → `busy` rises that edge, next `valid` 20 edges later, `result`=4'b1000.
- `abort` at edge 12 of a scan, then a fresh `start` → `valid` never rises for the aborted scan, `result` keeps its prior value, and the new scan completes normally after 20 edges.
- Drop `reset_n` asynchronously mid-SETTLE of channel 2 → all outputs 0 immediately without waiting for a clock edge. After release, `start` performs a full scan with a correct `result`.
